battle_state_manager: RTL and testbench

Game-flow sequencer for the battle screen. It replaces the hard-wired `state = 2'b01` in `top`, which currently fixes the game in the dodge phase. The block consumes keyboard scancodes, the per-frame tick and the player HP. It drives the 2-bit game state shared by the border, player and bullet sprites, and animates the four battle-box border coordinates between the wide (menu) box and the narrow (dodge) box, one step per frame. It also times each dodge turn.

---
 rtl/battle_state_manager.sv | 180 ++++++++++++++++++
 tb/tb_battle_state_manager.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/battle_state_manager.sv
// battle_state_manager: game-flow sequencer for the battle screen.
//   Decodes key presses from the keyboard scancode pair. Sequences
//   TITLE -> ACTION -> DODGE -> (ACTION | GAME_OVER) -> TITLE. Animates the
//   four battle-box edges toward the box for the current state, one step per
//   frame, and times each dodge turn.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   frame_tick            one-cycle pulse per frame
//   keycode[15:0]         {previous byte, latest byte} from the keyboard
//   hp[1:0]               player HP
//   state[1:0]            00 TITLE, 01 DODGE, 10 ACTION, 11 GAME_OVER
//   left/right/top/bottomBorder[8:0]  current box edges
//   border_busy           some edge has not yet reached its target
//   time_left[11:0]       dodge frames remaining
//   turn_count[7:0]       dodge turns started, saturating at 255
//   hp_restore            one-cycle HP refill pulse on GAME_OVER -> TITLE

// Per-edge stepper: moves one edge toward its target by at most STEP,
// never overshooting.
module bsm_edge_step #(
  parameter int STEP = 4
) (
  input  logic [8:0] cur_edge,
  input  logic [8:0] tgt_edge,
  output logic [8:0] nxt_edge
);
  localparam logic [8:0] STEP_W = 9'(STEP);
  logic [8:0] diff, mv;
  logic       up;

  always_comb begin
    up       = cur_edge < tgt_edge;
    diff     = up ? (tgt_edge - cur_edge) : (cur_edge - tgt_edge);
    mv       = (diff > STEP_W) ? STEP_W : diff;
    nxt_edge = up ? (cur_edge + mv) : (cur_edge - mv);
  end
endmodule

module battle_state_manager #(
  parameter int         DODGE_FRAMES = 600,
  parameter int         STEP         = 4,
  parameter int         WIDE_L       = 32,
  parameter int         WIDE_R       = 480,
  parameter int         WIDE_T       = 240,
  parameter int         WIDE_B       = 400,
  parameter int         NARROW_L     = 176,
  parameter int         NARROW_R     = 336,
  parameter int         NARROW_T     = 240,
  parameter int         NARROW_B     = 400,
  parameter logic [7:0] KEY_ENTER    = 8'h5A,
  parameter logic [7:0] KEY_Z        = 8'h1A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [15:0] keycode,
  input  logic [1:0]  hp,
  output logic [1:0]  state,
  output logic [8:0]  leftBorder,
  output logic [8:0]  rightBorder,
  output logic [8:0]  topBorder,
  output logic [8:0]  bottomBorder,
  output logic        border_busy,
  output logic [11:0] time_left,
  output logic [7:0]  turn_count,
  output logic        hp_restore
);
  typedef enum logic [1:0] {
    S_TITLE  = 2'b00,
    S_DODGE  = 2'b01,
    S_ACTION = 2'b10,
    S_OVER   = 2'b11
  } state_e;

  // Edge index: 0 left, 1 right, 2 top, 3 bottom.
  localparam int NUM_EDGES = 4;
  localparam logic [NUM_EDGES-1:0][8:0] WIDE_BOX =
    {9'(WIDE_B), 9'(WIDE_T), 9'(WIDE_R), 9'(WIDE_L)};
  localparam logic [NUM_EDGES-1:0][8:0] NARROW_BOX =
    {9'(NARROW_B), 9'(NARROW_T), 9'(NARROW_R), 9'(NARROW_L)};
  localparam logic [11:0] DODGE_W = 12'(DODGE_FRAMES);

  state_e                     state_q, state_d;
  logic [15:0]                keycode_q;
  logic [NUM_EDGES-1:0][8:0]  edge_q, edge_d, edge_nxt, tgt;
  logic [11:0]                time_left_q, time_left_d;
  logic [7:0]                 turn_count_q, turn_count_d;
  logic                       hp_restore_q, hp_restore_d;
  logic                       press;

  // Typematic repeats leave keycode unchanged; break codes carry F0 as the
  // previous byte. Neither counts as a press.
  assign press = (keycode != keycode_q) && (keycode[15:8] != 8'hF0);

  assign tgt = (state_q == S_TITLE || state_q == S_ACTION) ? WIDE_BOX : NARROW_BOX;
  assign border_busy = (edge_q != tgt);

  for (genvar e = 0; e < NUM_EDGES; e++) begin : g_edge
    bsm_edge_step #(.STEP(STEP)) u_step (
      .cur_edge (edge_q[e]),
      .tgt_edge (tgt[e]),
      .nxt_edge (edge_nxt[e])
    );
  end

  // Edges follow the target of the state registered at the tick, so a
  // state change in the same cycle only takes effect on the next tick.
  assign edge_d = frame_tick ? edge_nxt : edge_q;

  always_comb begin
    state_d      = state_q;
    time_left_d  = time_left_q;
    turn_count_d = turn_count_q;
    hp_restore_d = 1'b0;
    case (state_q)
      S_TITLE: begin
        if (press && keycode[7:0] == KEY_ENTER) begin
          state_d      = S_ACTION;
          turn_count_d = 8'd0;
        end
      end
      S_ACTION: begin
        // Z while the box is still moving is dropped, not queued.
        if (press && keycode[7:0] == KEY_Z && !border_busy) begin
          state_d      = S_DODGE;
          time_left_d  = DODGE_W;
          turn_count_d = (turn_count_q == 8'hFF) ? turn_count_q : turn_count_q + 8'd1;
        end
      end
      S_DODGE: begin
        // Death outranks timer expiry; the timer holds while the box shrinks.
        if (hp == 2'd0) begin
          state_d = S_OVER;
        end else if (frame_tick && !border_busy) begin
          if (time_left_q == 12'd1) begin
            state_d     = S_ACTION;
            time_left_d = 12'd0;
          end else begin
            time_left_d = time_left_q - 12'd1;
          end
        end
      end
      S_OVER: begin
        if (press && keycode[7:0] == KEY_ENTER) begin
          state_d      = S_TITLE;
          time_left_d  = 12'd0;
          hp_restore_d = 1'b1;
        end
      end
      default: state_d = S_TITLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_TITLE;
      keycode_q    <= keycode;
      edge_q       <= WIDE_BOX;
      time_left_q  <= 12'd0;
      turn_count_q <= 8'd0;
      hp_restore_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      keycode_q    <= keycode;
      edge_q       <= edge_d;
      time_left_q  <= time_left_d;
      turn_count_q <= turn_count_d;
      hp_restore_q <= hp_restore_d;
    end
  end

  assign state        = state_q;
  assign leftBorder   = edge_q[0];
  assign rightBorder  = edge_q[1];
  assign topBorder    = edge_q[2];
  assign bottomBorder = edge_q[3];
  assign time_left    = time_left_q;
  assign turn_count   = turn_count_q;
  assign hp_restore   = hp_restore_q;
endmodule

// File: tb/tb_battle_state_manager.sv
// Directed bench for battle_state_manager. The main instance runs at default
// parameters; a second instance with a 2-frame turn and a one-frame animation
// shares the inputs and is used for the 256-turn saturation scenario.
module tb_battle_state_manager;
  logic        clk = 1'b0;
  logic        reset, frame_tick;
  logic [15:0] keycode;
  logic [1:0]  hp;

  logic [1:0]  state, s_state;
  logic [8:0]  lb, rb, tb_e, bb, s_lb, s_rb, s_tb, s_bb;
  logic        busy, s_busy, hpr, s_hpr;
  logic [11:0] tl, s_tl;
  logic [7:0]  tc, s_tc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  battle_state_manager dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .keycode(keycode), .hp(hp),
    .state(state), .leftBorder(lb), .rightBorder(rb), .topBorder(tb_e), .bottomBorder(bb),
    .border_busy(busy), .time_left(tl), .turn_count(tc), .hp_restore(hpr)
  );

  battle_state_manager #(.DODGE_FRAMES(2), .STEP(160)) u_sat (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .keycode(keycode), .hp(hp),
    .state(s_state), .leftBorder(s_lb), .rightBorder(s_rb), .topBorder(s_tb), .bottomBorder(s_bb),
    .border_busy(s_busy), .time_left(s_tl), .turn_count(s_tc), .hp_restore(s_hpr)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic key(input logic [15:0] kc);
    keycode = kc;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; keycode = 16'h005A; hp = 2'd3;
    step(); step();
    reset = 1'b0;
    step();
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_state got %b exp 00", state); end
    n_cmp++; if ({lb, rb, tb_e, bb} !== {9'd32, 9'd480, 9'd240, 9'd400}) begin n_err++;
      $display("FAIL reset_borders got %0d/%0d/%0d/%0d exp 32/480/240/400", lb, rb, tb_e, bb); end
    n_cmp++; if ({busy, tl, tc, hpr} !== {1'b0, 12'd0, 8'd0, 1'b0}) begin n_err++;
      $display("FAIL reset_misc got busy=%b tl=%0d tc=%0d hpr=%b exp 0/0/0/0", busy, tl, tc, hpr); end
    step(); step();
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_no_press got %b exp 00", state); end
  endtask

  task automatic test_start_turn();
    key(16'h0000);
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL other_key_title got %b exp 00", state); end
    key(16'h005A);
    n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL enter_to_action got %b exp 10", state); end
    key(16'h5A1A);
    n_cmp++; if ({state, tl, tc, busy} !== {2'b01, 12'd600, 8'd1, 1'b1}) begin n_err++;
      $display("FAIL z_to_dodge got st=%b tl=%0d tc=%0d busy=%b exp 01/600/1/1", state, tl, tc, busy); end
    tick(1);
    n_cmp++; if ({lb, rb, tl} !== {9'd36, 9'd476, 12'd600}) begin n_err++;
      $display("FAIL shrink_tick1 got l=%0d r=%0d tl=%0d exp 36/476/600", lb, rb, tl); end
    tick(1);
    n_cmp++; if (lb !== 9'd40) begin n_err++; $display("FAIL shrink_tick2 got %0d exp 40", lb); end
    step();
    n_cmp++; if (lb !== 9'd40) begin n_err++; $display("FAIL no_move_between_ticks got %0d exp 40", lb); end
    tick(33);
    n_cmp++; if ({lb, busy} !== {9'd172, 1'b1}) begin n_err++;
      $display("FAIL shrink_tick35 got l=%0d busy=%b exp 172/1", lb, busy); end
    tick(1);
    n_cmp++; if ({lb, rb, tb_e, bb, busy, tl} !== {9'd176, 9'd336, 9'd240, 9'd400, 1'b0, 12'd600}) begin n_err++;
      $display("FAIL shrink_done got %0d/%0d/%0d/%0d busy=%b tl=%0d exp 176/336/240/400 0 600", lb, rb, tb_e, bb, busy, tl); end
  endtask

  task automatic test_expiry();
    tick(599);
    n_cmp++; if ({state, tl} !== {2'b01, 12'd1}) begin n_err++;
      $display("FAIL tick599 got st=%b tl=%0d exp 01/1", state, tl); end
    tick(1);
    // Edges hold: the tick that expired the turn used the narrow target.
    n_cmp++; if ({state, tl, lb, busy} !== {2'b10, 12'd0, 9'd176, 1'b1}) begin n_err++;
      $display("FAIL expire got st=%b tl=%0d l=%0d busy=%b exp 10/0/176/1", state, tl, lb, busy); end
  endtask

  task automatic test_busy_gating();
    tick(2);
    key(16'hF01A);
    n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL break_code got %b exp 10", state); end
    key(16'h001A);
    n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL z_while_busy got %b exp 10", state); end
    tick(34);
    n_cmp++; if ({lb, rb, busy} !== {9'd32, 9'd480, 1'b0}) begin n_err++;
      $display("FAIL expand_done got l=%0d r=%0d busy=%b exp 32/480/0", lb, rb, busy); end
    step();
    n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL z_not_queued got %b exp 10", state); end
    key(16'h1A1A);
    step(); step();
    n_cmp++; if ({state, tc, tl} !== {2'b01, 8'd2, 12'd600}) begin n_err++;
      $display("FAIL repeat_one_press got st=%b tc=%0d tl=%0d exp 01/2/600", state, tc, tl); end
  endtask

  task automatic test_death();
    tick(36 + 599);
    n_cmp++; if ({state, tl} !== {2'b01, 12'd1}) begin n_err++;
      $display("FAIL pre_death got st=%b tl=%0d exp 01/1", state, tl); end
    hp = 2'd0;
    tick(1);
    hp = 2'd3;
    n_cmp++; if (state !== 2'b11) begin n_err++; $display("FAIL death_wins got %b exp 11", state); end
    key(16'h005A);
    n_cmp++; if ({state, hpr, tl, tc} !== {2'b00, 1'b1, 12'd0, 8'd2}) begin n_err++;
      $display("FAIL over_to_title got st=%b hpr=%b tl=%0d tc=%0d exp 00/1/0/2", state, hpr, tl, tc); end
    step();
    n_cmp++; if ({hpr, tc} !== {1'b0, 8'd2}) begin n_err++;
      $display("FAIL hp_restore_1cyc got hpr=%b tc=%0d exp 0/2", hpr, tc); end
    key(16'h0000);
    key(16'h005A);
    n_cmp++; if ({state, tc} !== {2'b10, 8'd0}) begin n_err++;
      $display("FAIL turn_clear got st=%b tc=%0d exp 10/0", state, tc); end
  endtask

  task automatic test_saturation();
    reset = 1'b1; step(); reset = 1'b0;
    key(16'h0000);
    key(16'h005A);
    for (int i = 0; i < 256; i++) begin
      key((i % 2 == 0) ? 16'h001A : 16'h1A1A);
      tick(4);
      if (i == 253) begin
        n_cmp++; if ({s_tc, s_state} !== {8'd254, 2'b10}) begin n_err++;
          $display("FAIL sat_254 got tc=%0d st=%b exp 254/10", s_tc, s_state); end
      end
    end
    n_cmp++; if ({s_tc, s_state, s_busy} !== {8'd255, 2'b10, 1'b0}) begin n_err++;
      $display("FAIL sat_256 got tc=%0d st=%b busy=%b exp 255/10/0", s_tc, s_state, s_busy); end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1; step(); reset = 1'b0;
    key(16'h0000);
    key(16'h005A);
    key(16'h001A);
    tick(5);
    n_cmp++; if ({state, lb, tc} !== {2'b01, 9'd52, 8'd1}) begin n_err++;
      $display("FAIL pre_reset got st=%b l=%0d tc=%0d exp 01/52/1", state, lb, tc); end
    reset = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n_cmp++; if ({state, lb, rb, tb_e, bb, busy, tl, tc, hpr} !==
                 {2'b00, 9'd32, 9'd480, 9'd240, 9'd400, 1'b0, 12'd0, 8'd0, 1'b0}) begin n_err++;
      $display("FAIL mid_reset got st=%b %0d/%0d/%0d/%0d busy=%b tl=%0d tc=%0d hpr=%b exp 00 32/480/240/400 0 0 0 0",
               state, lb, rb, tb_e, bb, busy, tl, tc, hpr); end
    reset = 1'b0;
    step();
    n_cmp++; if ({state, lb} !== {2'b00, 9'd32}) begin n_err++;
      $display("FAIL post_reset got st=%b l=%0d exp 00/32", state, lb); end
  endtask

  initial begin
    test_reset();
    test_start_turn();
    test_expiry();
    test_busy_gating();
    test_death();
    test_saturation();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
